cordic_pre_processing_unit: RTL
===============================

// Module: cordic_pre_processing_unit
// PURPOSE
//  Front end of the CORDIC sine/cosine path; the complement of the output post-processing negate stage.
//  Folds a signed Q3.13 radian angle into the CORDIC convergence range [-pi/2, +pi/2].
//  Emits the folded angle (Cordic_z_out) plus Cos_negate_out / Sin_negate_out.
//  The flags travel alongside the CORDIC core and drive the post-processing negate stage.
//  Two-stage valid/ready pipeline.
// PARAMETERS
//  DATA_W  16  angle width, two's complement
//  FRAC_W  13  fractional bits (Q3.13: range [-4.0, +4.0) rad)
// PORTS
//  clk             in   1       single clock, rising edge
//  rst_n           in   1       asynchronous, active-low reset
//  In_valid        in   1       Angle_in valid
//  In_ready        out  1       block accepts Angle_in this cycle
//  Angle_in        in   DATA_W  signed angle, Q3.13 rad
//  Out_valid       out  1       outputs valid
//  Out_ready       in   1       downstream (CORDIC core) accepts
//  Cordic_z_out    out  DATA_W  folded angle, signed Q3.13, within [-HALF_PI_Q, +HALF_PI_Q]
//  Cos_negate_out  out  1       post stage must negate cos
//  Sin_negate_out  out  1       post stage must negate sin
// BEHAVIOUR
//  - Reset (rst_n low, async): both stage valids = 0; Out_valid = 0; Cordic_z_out = 0; both negate flags = 0.
//    Any in-flight data is discarded. First acceptance is allowed on the first clk edge after release.
//  - Transfer rules:
//    - Input transfer occurs when In_valid && In_ready; output transfer when Out_valid && Out_ready.
//    - Stage k loads when it is empty, or when its content moves on in the same cycle.
//    - In_ready = !s1_valid || s1_advance.
//  - Latency: 2 cycles from input transfer to Out_valid. Throughput: 1 per clock. No bubbles under continuous ready.
//  - Out_valid and the output data hold stable while Out_ready = 0. No loss, no duplication.
//  - Stage 1 (range): see CONFIGURATION. Its result zr is in [-PI_Q, +PI_Q]. Compute in DATA_W+1 bits.
//  - Stage 2 (fold):
//    - zr >  HALF_PI_Q -> z = zr - PI_Q; Cos_negate = Sin_negate = 1.
//    - zr < -HALF_PI_Q -> z = zr + PI_Q; Cos_negate = Sin_negate = 1.
//    - otherwise       -> z = zr; both flags = 0. Exactly +/-HALF_PI_Q is not folded.
//  - Both flags are always equal. They are kept as separate ports to match the post stage.
//  - Simultaneous input and output transfer with both stages full: the pipe shifts, occupancy is unchanged.
//    In_ready stays 1 in that cycle.
// CONFIGURATION
//  RANGE_WRAP_EN defined:
//    Angle_in > PI_Q   -> zr = Angle_in - TWO_PI_Q.
//    Angle_in < -PI_Q  -> zr = Angle_in + TWO_PI_Q.
//    Any Q3.13 input is therefore legal.
//  RANGE_WRAP_EN undefined:
//    Angle_in > PI_Q  -> zr = PI_Q.
//    Angle_in < -PI_Q -> zr = -PI_Q.
//    Saturating clamp; no wrap adders.
// STRUCTURE
//  Package cordic_pkg: constants derived from FRAC_W.
//    PI_Q = 25736, HALF_PI_Q = 12868, TWO_PI_Q = 51472 (17-bit).
//  Package cordic_pkg: typedef cordic_quad_t {logic cos_neg; logic sin_neg;}.
//    This typedef is shared with the post-processing stage.
//  One natural sub-module: cordic_pipe_stage, a single valid/ready register slice parameterised on payload width.
//    Instantiate it twice.
// TESTING
//  1. Angle_in=0, Out_ready=1 -> 2 cycles later Cordic_z_out=0, flags 0/0, Out_valid one cycle.
//  2. Angle_in=19302 (+3pi/4)  -> Cordic_z_out=-6434, flags 1/1.
//     Angle_in=-19302          -> Cordic_z_out=+6434, flags 1/1.
//  3. Boundaries:
//     Angle_in=12868  -> 12868, flags 0.
//     Angle_in=-12868 -> -12868, flags 0.
//     Angle_in=25736  -> 0, flags 1/1.
//  4. Angle_in=30000:
//     with RANGE_WRAP_EN    -> 4264, flags 1/1.
//     without RANGE_WRAP_EN -> 0, flags 1/1.
//  5. Back-pressure: stream 5 angles with Out_ready=0 for 4 cycles.
//     -> In_ready drops after 2 accepted; all 5 emerge in order, unchanged, no drops.
//  6. Reset mid-stream: rst_n low for 1 cycle with both stages full.
//     -> Out_valid=0 immediately; next accepted angle emerges 2 cycles after acceptance.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants and flag type for the CORDIC sine/cosine pre/post-processing stages.
package cordic_pkg;

  localparam int DATA_W_DEF = 32'sd16;
  localparam int FRAC_W_DEF = 32'sd13;

  // pi with 24 fractional bits; narrower formats are rounded from this
  localparam int PI_Q24 = 32'sd52707179;

  function automatic int pi_q(input int frac_w);
    return (PI_Q24 + (32'sd1 <<< (32'sd23 - frac_w))) >>> (32'sd24 - frac_w);
  endfunction

  localparam logic signed [16:0] PI_Q      = 17'sd25736;
  localparam logic signed [16:0] HALF_PI_Q = 17'sd12868;
  localparam logic signed [16:0] TWO_PI_Q  = 17'sd51472;

  typedef struct packed {
    logic cos_neg;
    logic sin_neg;
  } cordic_quad_t;

endpackage

// File: rtl/cordic_pipe_stage.sv
// Single valid/ready register slice; refills in the same cycle its content drains.
module cordic_pipe_stage #(
  parameter int W = 32'sd8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_load;

  assign o_ready = !r_valid || i_ready;
  assign w_load  = i_valid && o_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Slice state: valid follows upstream whenever the slot is free or draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else begin
      if (o_ready) begin
        r_valid <= i_valid;
      end
      if (w_load) begin
        r_data <= i_data;
      end
    end
  end

endmodule

// File: rtl/cordic_pre_processing_unit.sv
// Folds a Q3.13 angle into [-pi/2, +pi/2] and emits the post-stage negate flags.
// Optional RANGE_WRAP_EN: wrap out-of-range inputs by 2*pi instead of clamping to +/-pi.
module cordic_pre_processing_unit
  import cordic_pkg::*;
#(
  parameter int DATA_W = 32'sd16,
  parameter int FRAC_W = 32'sd13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              In_valid,
  output logic              In_ready,
  input  logic [DATA_W-1:0] Angle_in,
  output logic              Out_valid,
  input  logic              Out_ready,
  output logic [DATA_W-1:0] Cordic_z_out,
  output logic              Cos_negate_out,
  output logic              Sin_negate_out
);

  localparam int PI_I = pi_q(FRAC_W);
  localparam logic signed [DATA_W:0]   L_PI_W = (DATA_W+1)'(PI_I);
  localparam logic signed [DATA_W-1:0] L_PI   = DATA_W'(PI_I);
  localparam logic signed [DATA_W-1:0] L_HALF = DATA_W'(PI_I >>> 32'sd1);
`ifdef RANGE_WRAP_EN
  localparam logic signed [DATA_W:0]   L_TWO_PI_W = (DATA_W+1)'(PI_I * 32'sd2);
`endif

  logic signed [DATA_W:0]   w_angle_x;
  logic signed [DATA_W:0]   w_zr;
  logic                     w_unused_zr_msb;
  logic                     w_s1_valid;
  logic                     w_s2_ready;
  logic [DATA_W-1:0]        w_s1_data;
  logic signed [DATA_W-1:0] w_s1_zr;
  logic signed [DATA_W-1:0] w_z;
  cordic_quad_t             w_quad;
  logic [DATA_W+1:0]        w_s2_in;
  logic [DATA_W+1:0]        w_s2_out;

  assign w_angle_x       = {Angle_in[DATA_W-1], Angle_in};
  // zr always lies within +/-pi, so the extra bit carries no information
  assign w_unused_zr_msb = w_zr[DATA_W];

  // Stage 1 range reduction into [-pi, +pi]
  always_comb begin
    w_zr = w_angle_x;
`ifdef RANGE_WRAP_EN
    if (w_angle_x > L_PI_W) begin
      w_zr = w_angle_x - L_TWO_PI_W;
    end else if (w_angle_x < -L_PI_W) begin
      w_zr = w_angle_x + L_TWO_PI_W;
    end else begin
      w_zr = w_angle_x;
    end
`else
    if (w_angle_x > L_PI_W) begin
      w_zr = L_PI_W;
    end else if (w_angle_x < -L_PI_W) begin
      w_zr = -L_PI_W;
    end else begin
      w_zr = w_angle_x;
    end
`endif
  end

  cordic_pipe_stage #(.W(DATA_W)) u_stage_range (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (In_valid),
    .o_ready (In_ready),
    .i_data  (w_zr[DATA_W-1:0]),
    .o_valid (w_s1_valid),
    .i_ready (w_s2_ready),
    .o_data  (w_s1_data)
  );

  assign w_s1_zr = w_s1_data;

  // Stage 2 fold by pi; exactly +/-pi/2 stays unfolded
  always_comb begin
    w_z    = w_s1_zr;
    w_quad = '{cos_neg: 1'b0, sin_neg: 1'b0};
    if (w_s1_zr > L_HALF) begin
      w_z    = w_s1_zr - L_PI;
      w_quad = '{cos_neg: 1'b1, sin_neg: 1'b1};
    end else if (w_s1_zr < -L_HALF) begin
      w_z    = w_s1_zr + L_PI;
      w_quad = '{cos_neg: 1'b1, sin_neg: 1'b1};
    end else begin
      w_z    = w_s1_zr;
      w_quad = '{cos_neg: 1'b0, sin_neg: 1'b0};
    end
  end

  assign w_s2_in = {w_z, w_quad};

  cordic_pipe_stage #(.W(DATA_W+2)) u_stage_fold (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_s1_valid),
    .o_ready (w_s2_ready),
    .i_data  (w_s2_in),
    .o_valid (Out_valid),
    .i_ready (Out_ready),
    .o_data  (w_s2_out)
  );

  assign Cordic_z_out   = w_s2_out[DATA_W+1:2];
  assign Cos_negate_out = w_s2_out[1];
  assign Sin_negate_out = w_s2_out[0];

endmodule
